fifo_sync_param: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the UART 8x8 FIFO, one clock domain.

---
 rtl/fifo_sync_param.sv | 101 ++++++++++
 tb/tb_fifo_sync_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with show-ahead read, occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and error pulses.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_C  = AFULL_TH[AW:0];
  localparam logic [AW:0] AEMPTY_C = AEMPTY_TH[AW:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] w_ptr_q, w_ptr_d;
  logic [AW-1:0] r_ptr_q, r_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_ok, wr_ok;

  // Request/accept: a write is taken when w_en is high and there is room, or a
  // read pops in the same cycle; a read is taken when r_en is high and the FIFO
  // holds data. No bypass: an empty FIFO never satisfies a read, even with a write.
  assign rd_ok = r_en & ~empty;
  assign wr_ok = w_en & (~full | rd_ok);

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + AW'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = w_en & ~wr_ok;
      underflow_d = r_en & ~rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; stale words are never visible
  // through the flags because occupancy is tracked only by count.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_ok) begin
      mem[w_ptr_q] <= w_data;
    end
  end

  assign r_data       = mem[r_ptr_q];
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed and short random test of fifo_sync_param against a queue-based model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] r_data;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model of FIFO contents and error pulses
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic          model_valid = 1'b0;

  always @(posedge clk) begin : model
    bit rd, wr;
    if (rst || clr) begin
      exp_q.delete();
      exp_ovf     <= 1'b0;
      exp_udf     <= 1'b0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      rd = r_en && (exp_q.size() > 0);
      wr = w_en && ((exp_q.size() < DEPTH) || rd);
      exp_ovf <= w_en && !wr;
      exp_udf <= r_en && !rd;
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(w_data);
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFT));
      chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AET));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
      if (exp_q.size() > 0) chk("r_data", 32'(r_data), 32'(exp_q[0]));
    end
  end

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                      input logic c = 1'b0, input logic r = 1'b0);
    w_en = we; w_data = wd; r_en = re; clr = c; rst = r;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    // 1. reset and idle
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);

    // 2. fill 0x10..0x17, then drain in order
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h10 + i), 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      if (i == 0) chk("fill_aempty1", 32'(almost_empty), 32'd1);
      if (i == 1) chk("fill_aempty2", 32'(almost_empty), 32'd0);
      if (i == 4) chk("fill_afull5", 32'(almost_full), 32'd0);
      if (i == 5) chk("fill_afull6", 32'(almost_full), 32'd1);
      if (i == 6) chk("fill_full7", 32'(full), 32'd0);
      if (i == 7) chk("fill_full8", 32'(full), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(r_data), 32'(8'h10 + i));
      step(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // 3. overflow while full, then simultaneous read/write while full
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0);
    step(1, 8'hAA, 0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    step(1, 8'hBB, 1);
    chk("ovf_pulse_gone", 32'(overflow), 32'd0);
    chk("fullrw_count", 32'(count), 32'd8);
    chk("fullrw_head", 32'(r_data), 32'h11);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullrw_last", 32'(r_data), 32'hBB);
      step(0, 8'h00, 1);
    end

    // 4. underflow on empty, then read+write while empty
    step(0, 8'h00, 1);
    chk("udf_pulse", 32'(underflow), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    step(1, 8'h55, 1);
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_udf", 32'(underflow), 32'd1);
    chk("emptyrw_data", 32'(r_data), 32'h55);
    step(0, 8'h00, 0);
    chk("udf_pulse_gone", 32'(underflow), 32'd0);
    step(0, 8'h00, 1);

    // 5. wrap with interleaved write/read pairs
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(8'hC0 + i), 0);
      chk("wrap_data", 32'(r_data), 32'(8'hC0 + i));
      chk("wrap_count1", 32'(count), 32'd1);
      step(0, 8'h00, 1);
      chk("wrap_count0", 32'(count), 32'd0);
    end

    // 6. flush mid-burst with clr, then with rst
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'h99, 0, 1, 0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    step(1, 8'h77, 0);
    chk("clr_newdata", 32'(r_data), 32'h77);
    chk("clr_newcount", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h68 + i), 0);
    step(1, 8'h99, 0, 0, 1);
    chk("rstf_count", 32'(count), 32'd0);
    chk("rstf_empty", 32'(empty), 32'd1);
    chk("rstf_ovf", 32'(overflow), 32'd0);
    step(1, 8'h78, 0);
    chk("rstf_newdata", 32'(r_data), 32'h78);
    chk("rstf_newcount", 32'(count), 32'd1);

    // random traffic, scoreboard checks every cycle
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 60) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
